// File: rtl/decipher_ctrl.sv
// Sequencer and round-key store for one decipher core: accepts ciphertext,
// launches the core, serves round keys by round number, returns plaintext.
module decipher_ctrl #(
    parameter int TIMEOUT        = 32,
    parameter int Nb             = 4,
    parameter int ROUND_KEY_BITS = 128,
    parameter int BLK_S          = 128,
    parameter int Nr_128         = 10,
    parameter int Nr_256         = 14
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      key_wr_en,
    input  logic [Nb-1:0]             key_wr_addr,
    input  logic [ROUND_KEY_BITS-1:0] key_wr_data,
    input  logic                      key_len,
    input  logic                      key_commit,
    input  logic                      in_valid,
    input  logic [BLK_S-1:0]          in_data,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [BLK_S-1:0]          out_data,
    input  logic                      out_ready,
    output logic                      err,
    output logic                      busy,
    output logic                      core_en,
    output logic [BLK_S-1:0]          core_ciphertext,
    output logic [Nb-1:0]             core_rounds_total,
    output logic [ROUND_KEY_BITS-1:0] core_round_key,
    input  logic [BLK_S-1:0]          core_plaintext,
    input  logic [Nb-1:0]             core_round_no,
    input  logic                      core_en_o
);
    // state | meaning
    // IDLE  | waiting for a block; key writes/commits accepted here only
    // START | core_en high for this single cycle, watchdog loaded
    // WAIT  | core running; capture on core_en_o or abort on watchdog expiry
    // OUT   | plaintext presented until out_ready handshake
    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_OUT} state_t;

    localparam int NKEYS = Nr_256 + 1;
    localparam int WDW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t                    state;
    logic [WDW-1:0]            wd;
    logic                      key_valid;
    logic                      len_q;
    logic                      key_we;
    logic [ROUND_KEY_BITS-1:0] key_mem [NKEYS];

    assign in_ready          = (state == S_IDLE) && key_valid;
    assign busy              = (state != S_IDLE);
    assign out_valid         = (state == S_OUT);
    assign core_en           = (state == S_START);
    assign core_rounds_total = len_q ? Nb'(Nr_256) : Nb'(Nr_128);
    assign key_we            = (state == S_IDLE) && key_wr_en && (int'(key_wr_addr) < NKEYS);

    always_ff @(posedge clk) begin
        if (key_we)
            key_mem[key_wr_addr] <= key_wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            core_round_key <= '0;
        else if (int'(core_round_no) < NKEYS)
            core_round_key <= key_mem[core_round_no];
        else
            core_round_key <= '0;
    end

    // Watchdog is a down-counter loaded in START so that err lands exactly
    // TIMEOUT cycles after the core_en cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= S_IDLE;
            wd              <= '0;
            err             <= 1'b0;
            key_valid       <= 1'b0;
            len_q           <= 1'b0;
            core_ciphertext <= '0;
            out_data        <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (key_commit) begin
                        key_valid <= 1'b1;
                        len_q     <= key_len;
                    end else if (key_wr_en) begin
                        key_valid <= 1'b0;
                    end
                    if (in_valid && in_ready) begin
                        core_ciphertext <= in_data;
                        state           <= S_START;
                    end
                end
                S_START: begin
                    wd    <= WDW'(TIMEOUT - 2);
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_en_o) begin
                        out_data <= core_plaintext;
                        state    <= S_OUT;
                    end else if (wd == '0) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        wd <= wd - 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/decipher_ctrl.md
# decipher_ctrl

Sequencer and key store for the `decipher` round datapath. Accepts ciphertext blocks over a valid/ready stream and holds the expanded round-key schedule (11 or 15 keys) in an internal register file. Launches the core, feeds `round_key` indexed by the core's `round_no` with one-cycle SRAM-like latency, and returns plaintext over a valid/ready stream. Sits between the AXI-side block FIFO/key-expansion logic and one `decipher` instance.

## Interface
- `TIMEOUT`, 32: max cycles from core launch to `en_o` before abort.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `key_wr_en`  in  1  write `key_wr_data` to key slot `key_wr_addr`.
- `key_wr_addr`  in  `Nb`  key slot 0..`Nr_256`; values >14 ignored.
- `key_wr_data`  in  `ROUND_KEY_BITS`  round key.
- `key_len`  in  1  0 = AES-128 (`Nr_128`), 1 = AES-256 (`Nr_256`); sampled on `key_commit`.
- `key_commit`  in  1  pulse: latch `key_len`, set key-valid.
- `in_valid` / `in_data`  in  1 / `BLK_S`  ciphertext stream.
- `in_ready`  out  1  = state IDLE and key-valid.
- `out_valid` / `out_data`  out  1 / `BLK_S`  plaintext stream.
- `out_ready`  in  1  downstream accept.
- `err`  out  1  one-cycle pulse on timeout.
- `busy`  out  1  state ≠ IDLE.
- Core side: `core_en`, `core_ciphertext[BLK_S]`, `core_rounds_total[Nb]`, `core_round_key[ROUND_KEY_BITS]` out; `core_plaintext[BLK_S]`, `core_round_no[Nb]`, `core_en_o` in.

## Operation
- States: IDLE, START, WAIT, OUT.
- IDLE: on `in_valid && in_ready`, register `in_data` into `core_ciphertext`, go START.
- START: `core_en`=1 for exactly this cycle, clear watchdog, go WAIT.
- WAIT: watchdog increments each cycle. On first cycle with `core_en_o`=1, capture `core_plaintext` into `out_data` and go OUT. If the watchdog reaches `TIMEOUT` first, pulse `err`, go IDLE, and produce no output. `en_o` wins if both occur in the same cycle.
- OUT: `out_valid`=1, `out_data` stable. On `out_ready`, go IDLE.
- `core_rounds_total` = 10 if latched len 0, else 14. Constant while busy.
- `core_round_key` <= key_mem[`core_round_no`] every clock, in all states. Out-of-range index (>14) returns 0.
- Key writes:
  - Accepted only in IDLE; ignored while busy.
  - Any accepted `key_wr_en` clears key-valid.
  - `key_commit` in IDLE sets key-valid and latches `key_len`; ignored while busy.
  - `key_wr_en` and `key_commit` in the same cycle: write lands and key-valid ends set.
- key_mem is not reset. Reset clears key-valid, so no block is accepted after reset until a commit.

## Timing
- Reset values: `in_ready`, `out_valid`, `core_en`, `err`, `busy` = 0; `out_data`, `core_ciphertext`, `core_round_key` = 0; `core_rounds_total` = `Nr_128`; state IDLE.
- `in_ready` depends on registered state only. A commit in cycle N makes `in_ready` high from N+1.
- Launch latency: accept at edge N, `core_en` high N+1, `busy` high N+1.
- Round-key latency: `round_no` sampled at edge K, key visible after edge K (one cycle).
- Capture: `core_en_o` high at edge M gives `out_valid` high after edge M+1.
- Throughput: one block in flight. Next accept is possible the cycle after `out_ready` handshake, i.e. `in_ready` is high after that edge.
- `out_valid` must not drop, nor `out_data` change, until handshake.
- Reset asserted mid-block: immediate return to reset values; the in-flight block is discarded.

## Test plan
- Load 11 FIPS-197 AES-128 round keys (slot 0 = 'h0f0e0d0c0b0a09080706050403020100), commit len 0, send 'h5ac5b47080b7cdd830047b6ad8e0c469 → `out_data` 'hffeeddccbbaa99887766554433221100, `core_rounds_total`=10.
- Load 15 AES-256 keys (slot 14 = 'h36de686d3cc21a37e97909bfcc79fc24), commit len 1, send 'h8960494b9049fceabf456751cab7a28e → same plaintext; `core_rounds_total`=14.
- Hold `out_ready`=0 for 20 cycles → `out_valid` and `out_data` stable, `in_ready`=0. Then release → `in_ready`=1 next cycle.
- Key write during WAIT → key_mem unchanged, result still correct. `key_wr_en` in IDLE → `in_ready` drops until commit.
- Stub core never raises `en_o` → `err` pulse exactly 32 cycles after `core_en`, `out_valid` never asserts, back to IDLE.
- Assert `reset` low in WAIT → all outputs at reset values asynchronously. `in_ready`=0 until recommit.
